div_ratio_ctrl: RTL and testbench
=================================

DIV_RATIO_CTRL -- requirements
Module: div_ratio_ctrl

Interface
REQ-001 The block SHALL have parameter DIV_W, default 16, giving the width of the divide ratio.
REQ-002 The block SHALL have parameter DIV_RST, default 2, giving the ratio loaded at reset; it must be even and >=2.
REQ-003 The block SHALL have port clk_in, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port en, input, 1 bit: run request for the divided output.
REQ-006 The block SHALL have port cfg_valid, input, 1 bit: a new ratio is offered.
REQ-007 The block SHALL have port cfg_div, input, DIV_W bits: the offered ratio.
REQ-008 The block SHALL have port cfg_ready, output, 1 bit: the block can accept a ratio.
REQ-009 The block SHALL have port cfg_err, output, 1 bit: one-cycle pulse flagging an illegal accepted ratio.
REQ-010 The block SHALL have port clk_out, output, 1 bit: divided square wave, registered.
REQ-011 The block SHALL have port tick, output, 1 bit: one-cycle pulse on each clk_out 0->1 transition.
REQ-012 The block SHALL have port active, output, 1 bit: high whenever the state is not IDLE.
REQ-013 The block SHALL have port div_cur, output, DIV_W bits: the ratio currently in effect.

Function
REQ-014 The block SHALL use three states, IDLE, RUN and DRAIN, plus an independent pend flag and a div_next register.
REQ-015 The half-period SHALL be HP = div_cur >> 1; the counter SHALL be DIV_W-1 bits wide.
REQ-016 In RUN or DRAIN, each cycle the count SHALL increment; when count == HP-1, the count SHALL go to 0 and clk_out SHALL toggle, giving an output period of exactly div_cur cycles at 50% duty.
REQ-017 tick SHALL be registered and SHALL be high for exactly the first cycle in which clk_out is 1.
REQ-018 Period end SHALL be defined as count == HP-1 with clk_out == 1, i.e. the cycle in which clk_out falls.
REQ-019 From IDLE with en == 1, the state SHALL go to RUN at the next edge, with count = 0 and clk_out = 0.
REQ-020 From RUN with en == 0, the state SHALL go to DRAIN; from DRAIN with en == 1, it SHALL return to RUN with no disturbance to count or clk_out.
REQ-021 At period end, the next state SHALL be IDLE if en == 0, and RUN otherwise.
REQ-022 In IDLE, count SHALL be held at 0, clk_out at 0 and tick at 0; the output SHALL never be truncated mid-period.
REQ-023 cfg_ready SHALL equal !pend && !rst; a handshake occurs on cfg_valid && cfg_ready.
REQ-024 A ratio is legal when it is even and >= 2; an illegal accepted ratio SHALL leave div_cur unchanged and SHALL pulse cfg_err in the next cycle.
REQ-025 A legal ratio accepted in IDLE (with en == 0) SHALL load div_cur at the next edge; pend SHALL stay 0.
REQ-026 A legal ratio accepted in any other case SHALL load div_next and set pend.
REQ-027 At period end with pend set, div_cur SHALL take div_next, pend SHALL clear and count SHALL restart at 0, so the new ratio governs the very next period.
REQ-028 If pend is set while in IDLE, the pending ratio SHALL be applied at the next edge.
REQ-029 When a handshake coincides with an IDLE->RUN transition, the ratio SHALL be handled as if the block were running (it goes pending).
REQ-030 When pend is set and en drops together, the pending ratio SHALL still be applied at the final period end before IDLE.
REQ-031 div_cur SHALL never change at any cycle other than a period end or in IDLE.

Reset
REQ-032 While rst is high at a clock edge, the block SHALL set: state IDLE, count 0, clk_out 0, tick 0, cfg_err 0, pend 0, div_next 0, div_cur DIV_RST.
REQ-033 While rst is high, active SHALL be 0 and cfg_ready SHALL be 0.
REQ-034 A reset asserted mid-period or with a ratio pending SHALL abort immediately; the pending ratio SHALL be discarded.

Verification
REQ-035 The bench SHALL cover: DIV_RST=4, en=1 held -> clk_out 2 high/2 low; tick once every 4 cycles; active=1.
REQ-036 The bench SHALL cover: running at 4, cfg_div=10 offered -> cfg_ready low until the next clk_out fall; the following period is 10 cycles (5/5); div_cur=10 from that cycle.
REQ-037 The bench SHALL cover: cfg_div=7, then cfg_div=0, accepted -> cfg_err pulses one cycle each; div_cur unchanged; clk_out period unchanged.
REQ-038 The bench SHALL cover: div 8 running, en dropped 1 cycle after clk_out rises -> clk_out stays high 3 more cycles, falls, then IDLE, active=0, no further tick.
REQ-039 The bench SHALL cover: en dropped with 6 pending over div 4 -> the current period completes at 4, IDLE entered, div_cur=6, cfg_ready=1.
REQ-040 The bench SHALL cover: rst pulsed mid-period with pend=1 -> next cycle clk_out=0, div_cur=DIV_RST, cfg_ready=1, state IDLE.

Source files
------------

// File: rtl/div_ratio_ctrl.sv
// Programmable even-ratio clock divider with a ready/valid ratio port.
// New ratios take effect only on a period boundary or while idle, so clk_out is never truncated.
module div_ratio_ctrl #(
    parameter int DIV_W   = 16,
    parameter int DIV_RST = 2
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             clk_out,
    output logic             tick,
    output logic             active,
    output logic [DIV_W-1:0] div_cur,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam logic [DIV_W-2:0] CNT_ONE = 1;

    state_e           state_q, state_d;
    logic [DIV_W-2:0] count_q, count_d;
    logic [DIV_W-2:0] hp_m1;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic             err_q, err_d;
    logic             pend_q, pend_d;
    logic [DIV_W-1:0] div_cur_q, div_cur_d;
    logic [DIV_W-1:0] div_next_q, div_next_d;
    logic             running;
    logic             half_end;
    logic             period_end;
    logic             accept;
    logic             legal;

    // Config handshake: a ratio transfers on any edge where cfg_valid && cfg_ready.
    // Only one ratio can be outstanding, so ready drops while one is pending.
    assign cfg_ready = !pend_q && !rst;
    assign accept    = cfg_valid && cfg_ready;
    assign legal     = !cfg_div[0] && (cfg_div != '0);

    assign hp_m1      = div_cur_q[DIV_W-1:1] - CNT_ONE;
    assign running    = (state_q != IDLE);
    assign half_end   = running && (count_q == hp_m1);
    assign period_end = half_end && clk_out_q;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        clk_out_d  = clk_out_q;
        tick_d     = 1'b0;
        err_d      = 1'b0;
        pend_d     = pend_q;
        div_cur_d  = div_cur_q;
        div_next_d = div_next_q;

        case (state_q)
            IDLE: begin
                count_d   = '0;
                clk_out_d = 1'b0;
                if (en) state_d = RUN;
            end
            RUN, DRAIN: begin
                if (half_end) begin
                    count_d   = '0;
                    clk_out_d = !clk_out_q;
                    tick_d    = !clk_out_q;
                end else begin
                    count_d = count_q + CNT_ONE;
                end
                if (period_end)
                    state_d = en ? RUN : IDLE;
                else if (state_q == RUN && !en)
                    state_d = DRAIN;
                else if (state_q == DRAIN && en)
                    state_d = RUN;
            end
            default: state_d = IDLE;
        endcase

        // A pending ratio lands on the boundary so the next period uses it in full.
        if (pend_q && (period_end || state_q == IDLE)) begin
            div_cur_d = div_next_q;
            pend_d    = 1'b0;
        end

        if (accept) begin
            if (!legal) begin
                err_d = 1'b1;
            end else if (state_q == IDLE && !en) begin
                div_cur_d = cfg_div;
            end else begin
                div_next_d = cfg_div;
                pend_d     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            clk_out_q  <= 1'b0;
            tick_q     <= 1'b0;
            err_q      <= 1'b0;
            pend_q     <= 1'b0;
            div_next_q <= '0;
            div_cur_q  <= DIV_W'(DIV_RST);
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            clk_out_q  <= clk_out_d;
            tick_q     <= tick_d;
            err_q      <= err_d;
            pend_q     <= pend_d;
            div_next_q <= div_next_d;
            div_cur_q  <= div_cur_d;
        end
    end

    assign clk_out   = clk_out_q;
    assign tick      = tick_q;
    assign cfg_err   = err_q;
    assign active    = running && !rst;
    assign div_cur   = div_cur_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_div_ratio_ctrl.sv
// Directed bench for div_ratio_ctrl: expected periods and error pulses are queued by the
// stimulus thread and consumed by a negedge monitor; point checks cover handshake timing.
module tb_div_ratio_ctrl;

    localparam int DIV_W   = 16;
    localparam int DIV_RST = 4;

    logic             clk_in = 1'b0;
    logic             rst;
    logic             en;
    logic             cfg_valid;
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_ready;
    logic             cfg_err;
    logic             clk_out;
    logic             tick;
    logic             active;
    logic [DIV_W-1:0] div_cur;
    logic [1:0]       dbg_state;

    div_ratio_ctrl #(.DIV_W(DIV_W), .DIV_RST(DIV_RST)) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .clk_out   (clk_out),
        .tick      (tick),
        .active    (active),
        .div_cur   (div_cur),
        .dbg_state (dbg_state)
    );

    // clock
    always #5 clk_in = !clk_in;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [15:0]      exp_per_q[$];   // {low cycles, high cycles}
    logic [DIV_W-1:0] exp_err_q[$];   // div_cur expected while cfg_err pulses

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_per(input int lo, input int hi, input int n);
        for (int i = 0; i < n; i++) exp_per_q.push_back({lo[7:0], hi[7:0]});
    endtask

    task automatic wait_tick();
        bit seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_in);
            if (tick) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            n_cmp++;
            n_fail++;
            $display("FAIL tick_timeout: got no tick expected one within 100 cycles");
        end
    endtask

    task automatic wait_idle();
        bit seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_in);
            if (!active) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            n_cmp++;
            n_fail++;
            $display("FAIL idle_timeout: got active=1 expected 0 within 100 cycles");
        end
    endtask

    task automatic offer(input logic [DIV_W-1:0] val);
        bit done = 1'b0;
        @(posedge clk_in); #1;
        cfg_valid = 1'b1;
        cfg_div   = val;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_in);
            if (cfg_ready) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL offer_timeout: got cfg_ready=0 expected 1 within 100 cycles");
        end
        @(posedge clk_in); #1;
        cfg_valid = 1'b0;
    endtask

    // Monitor: measures each clk_out period and consumes error pulses.
    logic       prev_clk = 1'b0;
    logic       rst_prev = 1'b0;
    logic       err_prev = 1'b0;
    logic [7:0] lo_c = 8'd0;
    logic [7:0] hi_c = 8'd0;
    logic [15:0] exp_per;
    logic [DIV_W-1:0] exp_dc;

    always @(negedge clk_in) begin
        if (rst || rst_prev) begin
            lo_c     = 8'd0;
            hi_c     = 8'd0;
            prev_clk = 1'b0;
        end else begin
            if (clk_out) begin
                if (!prev_clk) check("tick_on_rise", {31'd0, tick}, 32'd1);
                else if (tick) check("tick_spurious", {31'd0, tick}, 32'd0);
                hi_c = hi_c + 8'd1;
            end else begin
                if (tick) check("tick_while_low", {31'd0, tick}, 32'd0);
                if (prev_clk) begin
                    if (exp_per_q.size() == 0) begin
                        check("period_unexpected", {16'd0, lo_c, hi_c}, 32'd0);
                    end else begin
                        exp_per = exp_per_q.pop_front();
                        check("period_low", {24'd0, lo_c}, {24'd0, exp_per[15:8]});
                        check("period_high", {24'd0, hi_c}, {24'd0, exp_per[7:0]});
                    end
                    lo_c = 8'd0;
                    hi_c = 8'd0;
                end
                if (active) lo_c = lo_c + 8'd1;
            end
            prev_clk = clk_out;
        end
        if (err_prev) check("err_one_cycle", {31'd0, cfg_err}, 32'd0);
        if (cfg_err) begin
            if (exp_err_q.size() == 0) begin
                check("err_unexpected", {31'd0, cfg_err}, 32'd0);
            end else begin
                exp_dc = exp_err_q.pop_front();
                check("err_div_cur", {16'd0, div_cur}, {16'd0, exp_dc});
            end
        end
        err_prev = cfg_err;
        rst_prev = rst;
    end

    int tick_cnt;

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = '0;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        check("rst_cfg_ready", {31'd0, cfg_ready}, 32'd0);
        check("rst_active", {31'd0, active}, 32'd0);
        @(posedge clk_in); #1;
        rst = 1'b0;
        @(negedge clk_in);
        check("init_clk_out", {31'd0, clk_out}, 32'd0);
        check("init_tick", {31'd0, tick}, 32'd0);
        check("init_cfg_err", {31'd0, cfg_err}, 32'd0);
        check("init_div_cur", {16'd0, div_cur}, DIV_RST);
        check("init_cfg_ready", {31'd0, cfg_ready}, 32'd1);
        check("init_state", {30'd0, dbg_state}, 32'd0);

        // Ratio 4 free-running: three 2/2 periods.
        push_per(2, 2, 3);
        @(posedge clk_in); #1;
        en = 1'b1;
        for (int i = 0; i < 3; i++) wait_tick();
        check("run_active", {31'd0, active}, 32'd1);
        @(posedge clk_in); #1;
        en = 1'b0;
        wait_idle();

        // Switch 4 -> 10 while running; takes effect at the following boundary.
        push_per(2, 2, 2);
        push_per(5, 5, 2);
        @(posedge clk_in); #1;
        en = 1'b1;
        wait_tick();
        @(posedge clk_in); #1;
        cfg_valid = 1'b1;
        cfg_div   = 16'd10;
        @(negedge clk_in);
        check("sw_ready_offer", {31'd0, cfg_ready}, 32'd1);
        @(posedge clk_in); #1;
        cfg_valid = 1'b0;
        @(negedge clk_in);
        check("sw_ready_pend", {31'd0, cfg_ready}, 32'd0);
        check("sw_div_old", {16'd0, div_cur}, 32'd4);
        repeat (3) @(negedge clk_in);
        check("sw_ready_last", {31'd0, cfg_ready}, 32'd0);
        check("sw_div_last", {16'd0, div_cur}, 32'd4);
        check("sw_clk_last", {31'd0, clk_out}, 32'd1);
        @(negedge clk_in);
        check("sw_ready_after", {31'd0, cfg_ready}, 32'd1);
        check("sw_div_new", {16'd0, div_cur}, 32'd10);
        check("sw_clk_after", {31'd0, clk_out}, 32'd0);
        wait_tick();
        wait_tick();
        @(posedge clk_in); #1;
        en = 1'b0;
        wait_idle();

        // Illegal ratios 7 and 0 while running at 10.
        push_per(5, 5, 3);
        @(posedge clk_in); #1;
        en = 1'b1;
        wait_tick();
        exp_err_q.push_back(16'd10);
        offer(16'd7);
        exp_err_q.push_back(16'd10);
        offer(16'd0);
        wait_tick();
        wait_tick();
        @(posedge clk_in); #1;
        en = 1'b0;
        wait_idle();
        check("bad_div_kept", {16'd0, div_cur}, 32'd10);

        // Ratio 8 loaded while idle, then en dropped just after the rising edge.
        offer(16'd8);
        @(negedge clk_in);
        check("idle_load_div", {16'd0, div_cur}, 32'd8);
        check("idle_load_ready", {31'd0, cfg_ready}, 32'd1);
        push_per(4, 4, 1);
        @(posedge clk_in); #1;
        en = 1'b1;
        wait_tick();
        @(posedge clk_in); #1;
        en = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk_in);
            check("drain_high", {31'd0, clk_out}, 32'd1);
        end
        @(negedge clk_in);
        check("drain_fall", {31'd0, clk_out}, 32'd0);
        check("drain_inactive", {31'd0, active}, 32'd0);
        check("drain_idle", {30'd0, dbg_state}, 32'd0);
        tick_cnt = 0;
        repeat (12) begin
            @(negedge clk_in);
            if (tick) tick_cnt++;
        end
        check("idle_no_tick", tick_cnt, 32'd0);

        // Ratio 4 with 6 pending when en drops: period finishes at 4, then 6 applies.
        offer(16'd4);
        push_per(2, 2, 1);
        @(posedge clk_in); #1;
        en = 1'b1;
        @(posedge clk_in); #1;
        cfg_valid = 1'b1;
        cfg_div   = 16'd6;
        @(negedge clk_in);
        check("pd_ready_offer", {31'd0, cfg_ready}, 32'd1);
        @(posedge clk_in); #1;
        cfg_valid = 1'b0;
        en        = 1'b0;
        @(negedge clk_in);
        @(negedge clk_in);
        check("pd_ready_pend", {31'd0, cfg_ready}, 32'd0);
        check("pd_clk_high", {31'd0, clk_out}, 32'd1);
        @(negedge clk_in);
        check("pd_div_old", {16'd0, div_cur}, 32'd4);
        @(negedge clk_in);
        check("pd_div_new", {16'd0, div_cur}, 32'd6);
        check("pd_ready_after", {31'd0, cfg_ready}, 32'd1);
        check("pd_inactive", {31'd0, active}, 32'd0);
        check("pd_idle", {30'd0, dbg_state}, 32'd0);

        // Offer coinciding with IDLE->RUN goes pending; reset then aborts everything.
        @(posedge clk_in); #1;
        en        = 1'b1;
        cfg_valid = 1'b1;
        cfg_div   = 16'd8;
        @(negedge clk_in);
        check("st_ready_offer", {31'd0, cfg_ready}, 32'd1);
        @(posedge clk_in); #1;
        cfg_valid = 1'b0;
        @(negedge clk_in);
        check("st_div_kept", {16'd0, div_cur}, 32'd6);
        check("st_ready_pend", {31'd0, cfg_ready}, 32'd0);
        check("st_active", {31'd0, active}, 32'd1);
        @(posedge clk_in); #1;
        rst = 1'b1;
        @(negedge clk_in);
        check("mr_ready_in_rst", {31'd0, cfg_ready}, 32'd0);
        check("mr_active_in_rst", {31'd0, active}, 32'd0);
        @(posedge clk_in); #1;
        rst = 1'b0;
        en  = 1'b0;
        @(negedge clk_in);
        check("mr_clk_out", {31'd0, clk_out}, 32'd0);
        check("mr_div_cur", {16'd0, div_cur}, DIV_RST);
        check("mr_cfg_ready", {31'd0, cfg_ready}, 32'd1);
        check("mr_state", {30'd0, dbg_state}, 32'd0);
        check("mr_tick", {31'd0, tick}, 32'd0);

        repeat (6) @(negedge clk_in);
        check("per_queue_empty", exp_per_q.size(), 32'd0);
        check("err_queue_empty", exp_err_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
